// File: rtl/mips_io_bridge_if.sv
// Load/store bus between the MIPS core data path and the memory-mapped I/O bridge.
interface mips_io_bridge_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        IOSel;

  modport master (
    output MemWrite, MemRead, Address, WriteData,
    input  ReadData, IOSel
  );

  modport slave (
    input  MemWrite, MemRead, Address, WriteData,
    output ReadData, IOSel
  );
endinterface

// File: rtl/mips_io_bridge.sv
// Memory-mapped I/O bridge: output port register, synchronised and debounced input port,
// sticky change/edge status with an interrupt line.
module mips_io_bridge #(
  parameter logic [31:0] IO_BASE         = 32'h1001_0024,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  mips_io_bridge_if.slave bus,
  input  logic [7:0]      PortIn,
  output logic [31:0]     PortOut,
  output logic            IRQ
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t        state, state_n;
  logic [31:0]   offset;
  logic          hit;
  logic [7:0]    sync1, sync2;
  logic [7:0]    cand, cand_n;
  logic [7:0]    debounced;
  logic [7:0]    edge_bits;
  logic [CW-1:0] count, count_n;
  logic          accept;
  logic          changed, irq_en;
  logic          wr_out, wr_status, clear;
  logic          unused_memread;

  // Registers sit at base+0..base+C, so decode on the offset from the base.
  assign offset    = bus.Address - IO_BASE;
  assign hit       = (offset[31:4] == 28'd0) && (offset[1:0] == 2'd0);
  assign bus.IOSel = hit;

  assign wr_out    = bus.MemWrite && hit && (offset[3:2] == 2'd0);
  assign wr_status = bus.MemWrite && hit && (offset[3:2] == 2'd2);
  assign clear     = wr_status && bus.WriteData[0];

  assign IRQ            = changed & irq_en;
  assign unused_memread = bus.MemRead;

  always_comb begin
    bus.ReadData = 32'd0;
    if (hit) begin
      case (offset[3:2])
        2'd0:    bus.ReadData = PortOut;
        2'd1:    bus.ReadData = {24'd0, debounced};
        2'd2:    bus.ReadData = {30'd0, irq_en, changed};
        default: bus.ReadData = {24'd0, edge_bits};
      endcase
    end
  end

  always_comb begin
    state_n = state;
    cand_n  = cand;
    count_n = count;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (sync2 != debounced) begin
          cand_n  = sync2;
          count_n = CW'(1);
          state_n = COUNT;
        end
      end
      COUNT: begin
        if (sync2 == debounced) begin
          state_n = IDLE;
        end else if (sync2 != cand) begin
          cand_n  = sync2;
          count_n = CW'(1);
        end else if (count == COUNT_MAX) begin
          accept  = 1'b1;
          state_n = IDLE;
        end else begin
          count_n = count + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage boundary: pin synchroniser and debounce state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 8'd0;
      sync2 <= 8'd0;
      state <= IDLE;
      cand  <= 8'd0;
      count <= '0;
    end else begin
      sync1 <= PortIn;
      sync2 <= sync1;
      state <= state_n;
      cand  <= cand_n;
      count <= count_n;
    end
  end

  // Stage boundary: architectural registers; a new acceptance beats a same-edge clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PortOut   <= 32'd0;
      debounced <= 8'd0;
      changed   <= 1'b0;
      irq_en    <= 1'b0;
      edge_bits <= 8'd0;
    end else begin
      if (wr_out)    PortOut <= bus.WriteData;
      if (wr_status) irq_en  <= bus.WriteData[1];
      if (accept) begin
        debounced <= cand;
        changed   <= 1'b1;
        edge_bits <= (clear ? 8'd0 : edge_bits) | (cand ^ debounced);
      end else if (clear) begin
        changed   <= 1'b0;
        edge_bits <= 8'd0;
      end
    end
  end
endmodule

// File: tb/tb_mips_io_bridge.sv
// Directed bench for mips_io_bridge: decode, port registers, debounce timing, W1C status and IRQ.
module tb_mips_io_bridge;
  localparam logic [31:0] BASE = 32'h1001_0024;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  port_in;
  logic [31:0] port_out;
  logic        irq;
  int          n_tests = 0;
  int          n_fail  = 0;

  mips_io_bridge_if bus_if ();

  mips_io_bridge #(.IO_BASE(BASE), .DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if),
    .PortIn (port_in),
    .PortOut(port_out),
    .IRQ    (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
    bus_if.Address = BASE + off;
    #1;
    chk(tag, bus_if.ReadData, exp);
  endtask

  task automatic chk_sel(input string tag, input logic [31:0] addr, input logic exp_sel);
    bus_if.Address = addr;
    #1;
    chk({tag, "_iosel"}, {31'd0, bus_if.IOSel}, {31'd0, exp_sel});
    if (!exp_sel) chk({tag, "_rdata"}, bus_if.ReadData, 32'd0);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    bus_if.Address   = BASE + off;
    bus_if.WriteData = data;
    bus_if.MemWrite  = 1'b1;
    tick();
    bus_if.MemWrite  = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    port_in          = 8'h00;
    bus_if.MemWrite  = 1'b0;
    bus_if.MemRead   = 1'b0;
    bus_if.Address   = 32'd0;
    bus_if.WriteData = 32'd0;
    tick(2);
    reset = 1'b0;

    chk("rst_portout", port_out, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk_rd("rst_status", 32'h8, 32'd0);
    chk_rd("rst_portin", 32'h4, 32'd0);

    // Output port write/readback and address decode.
    wr(32'h0, 32'h0000_00A5);
    chk("sw_portout", port_out, 32'h0000_00A5);
    chk_rd("lw_portout", 32'h0, 32'h0000_00A5);
    chk_sel("sel_base", BASE, 1'b1);
    chk_sel("sel_plusc", BASE + 32'hC, 1'b1);
    chk_sel("sel_plus10", BASE + 32'h10, 1'b0);
    chk_sel("sel_minus4", BASE - 32'h4, 1'b0);
    chk_sel("sel_misalign", BASE + 32'h2, 1'b0);
    wr(32'h4, 32'h0000_00FF);
    chk("wr_portin_ignored", port_out, 32'h0000_00A5);
    chk_rd("portin_ro", 32'h4, 32'd0);
    wr(32'h10, 32'h0000_FFFF);
    chk("wr_outside_ignored", port_out, 32'h0000_00A5);

    // Clean change accepted after edge 7, not edge 6.
    port_in = 8'h3C;
    tick(6);
    chk_rd("pin_edge6", 32'h4, 32'd0);
    tick();
    chk_rd("pin_edge7", 32'h4, 32'h3C);
    chk_rd("status_edge7", 32'h8, 32'h1);
    chk_rd("edge_edge7", 32'hC, 32'h3C);
    chk("irq_disabled", {31'd0, irq}, 32'd0);

    // Enable IRQ without clearing, then reset mid-cycle.
    wr(32'h8, 32'h2);
    chk("irq_enabled", {31'd0, irq}, 32'd1);
    chk_rd("status_en", 32'h8, 32'h3);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_portout", port_out, 32'd0);
    chk("async_rst_irq", {31'd0, irq}, 32'd0);
    chk_rd("async_rst_status", 32'h8, 32'd0);
    chk_rd("async_rst_portin", 32'h4, 32'd0);
    port_in = 8'h00;
    tick();
    reset = 1'b0;

    // Two-cycle glitch must be rejected.
    port_in = 8'hFF;
    tick(2);
    port_in = 8'h00;
    tick(8);
    chk_rd("glitch_portin", 32'h4, 32'd0);
    chk_rd("glitch_status", 32'h8, 32'd0);

    // IRQ on acceptance, then clear collides with a second acceptance.
    wr(32'h8, 32'h2);
    chk("irq_no_change", {31'd0, irq}, 32'd0);
    chk_rd("status_en_only", 32'h8, 32'h2);
    port_in = 8'h10;
    tick(7);
    chk("irq_on_accept", {31'd0, irq}, 32'd1);
    chk_rd("pin_10", 32'h4, 32'h10);
    chk_rd("status_accept", 32'h8, 32'h3);
    chk_rd("edge_10", 32'hC, 32'h10);
    port_in = 8'h11;
    tick(6);
    chk_rd("pin_before_2nd", 32'h4, 32'h10);
    wr(32'h8, 32'h3);
    chk("irq_set_wins", {31'd0, irq}, 32'd1);
    chk_rd("status_set_wins", 32'h8, 32'h3);
    chk_rd("edge_new_only", 32'hC, 32'h01);
    chk_rd("pin_11", 32'h4, 32'h11);

    // Clear and disable, then a bouncing input that settles to 0x81.
    wr(32'h8, 32'h1);
    chk_rd("status_cleared", 32'h8, 32'd0);
    chk_rd("edge_cleared", 32'hC, 32'd0);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    port_in = 8'h81;
    tick(2);
    port_in = 8'h80;
    tick();
    port_in = 8'h81;
    tick(6);
    chk_rd("bounce_pin_early", 32'h4, 32'h11);
    tick();
    chk_rd("bounce_pin_81", 32'h4, 32'h81);
    chk_rd("bounce_status", 32'h8, 32'h1);
    chk_rd("bounce_edge", 32'hC, 32'h90);
    chk("bounce_irq_off", {31'd0, irq}, 32'd0);

    // Status write with bit0=0 keeps sticky bits; EDGE is read-only.
    wr(32'h8, 32'h2);
    chk_rd("status_keep", 32'h8, 32'h3);
    chk("irq_late_enable", {31'd0, irq}, 32'd1);
    wr(32'hC, 32'hFF);
    chk_rd("edge_ro", 32'hC, 32'h90);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
